// File: rtl/jump_scroll_ctrl_if.sv
// rtl/jump_scroll_ctrl_if.sv - game-side control inputs and physics/scroll outputs of jump_scroll_ctrl
interface jump_scroll_ctrl_if;
  logic [1:0]  state;
  logic        tick;
  logic        land;
  logic [8:0]  player_y;
  logic [3:0]  adv;
  logic [5:0]  vel;
  logic        falling;
  logic        dead;
  logic [15:0] score;

  modport master (
    output state, tick, land,
    input  player_y, adv, vel, falling, dead, score
  );

  modport slave (
    input  state, tick, land,
    output player_y, adv, vel, falling, dead, score
  );
endinterface

// File: rtl/jump_scroll_ctrl.sv
// rtl/jump_scroll_ctrl.sv - player vertical physics, scroll advance, score and death detection
module jump_scroll_ctrl #(
  parameter int START_Y     = 400,
  parameter int SCROLL_LINE = 200,
  parameter int JUMP_V      = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 8,
  parameter int BOTTOM      = 480
) (
  input logic              clk,
  input logic              rst,
  jump_scroll_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam logic [1:0]         STATE_PLAYING = 2'd2;
  localparam logic [8:0]         START_Y_V     = 9'(START_Y);
  localparam logic [8:0]         FLOOR_Y       = 9'(BOTTOM - 1);
  localparam logic [8:0]         SCROLL_Y      = 9'(SCROLL_LINE);
  localparam logic signed [10:0] SCROLL_S      = 11'(SCROLL_LINE);
  localparam logic signed [10:0] BOTTOM_S      = 11'(BOTTOM);
  localparam logic signed [10:0] ADV_MAX_S     = 11'sd15;
  localparam logic signed [5:0]  LAUNCH_VEL    = 6'(-JUMP_V);
  localparam logic signed [6:0]  GRAVITY_S     = 7'(GRAVITY);
  localparam logic signed [6:0]  MAX_FALL_S    = 7'(MAX_FALL);
  localparam logic signed [5:0]  MAX_FALL_V    = 6'(MAX_FALL);

  logic [1:0]         fsm;
  logic [8:0]         y_q;
  logic signed [5:0]  vel_q;
  logic [3:0]         adv_q;
  logic [15:0]        score_q;

  logic signed [10:0] y_new;
  logic signed [10:0] ov;
  logic [3:0]         adv_step;
  logic [8:0]         y_scroll;
  logic signed [6:0]  vel_sum;
  logic signed [5:0]  vel_next;
  logic [16:0]        score_sum;
  logic [15:0]        score_next;
  logic               rising;
  logic               landing;
  logic               hit_top;
  logic               hit_bottom;

  // Position math is done in 11-bit signed so upward overshoot past y=0 cannot wrap.
  always_comb begin
    rising     = vel_q[5];
    landing    = bus.land && !rising;
    y_new      = $signed({2'b00, y_q}) + $signed({{5{vel_q[5]}}, vel_q});
    ov         = SCROLL_S - y_new;
    adv_step   = (ov > ADV_MAX_S) ? 4'd15 : ov[3:0];
    y_scroll   = SCROLL_Y + ov[8:0] - {5'b0, adv_step};
    hit_top    = rising && (y_new < SCROLL_S);
    hit_bottom = y_new >= BOTTOM_S;
    vel_sum    = $signed({vel_q[5], vel_q}) + GRAVITY_S;
    vel_next   = (vel_sum > MAX_FALL_S) ? MAX_FALL_V : vel_sum[5:0];
    score_sum  = {1'b0, score_q} + {13'b0, adv_q};
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.state != STATE_PLAYING) begin
      fsm     <= S_IDLE;
      y_q     <= START_Y_V;
      vel_q   <= '0;
      adv_q   <= '0;
      score_q <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          fsm   <= S_PLAY;
          y_q   <= START_Y_V;
          vel_q <= LAUNCH_VEL;
          adv_q <= '0;
        end
        S_PLAY: begin
          adv_q <= '0;
          if (adv_q != 4'd0)
            score_q <= score_next;
          if (bus.tick) begin
            if (landing) begin
              vel_q <= LAUNCH_VEL;
            end else begin
              // Position uses the pre-gravity velocity.
              vel_q <= vel_next;
              if (hit_top) begin
                adv_q <= adv_step;
                y_q   <= y_scroll;
              end else if (hit_bottom) begin
                fsm <= S_DEAD;
                y_q <= FLOOR_Y;
              end else begin
                y_q <= y_new[8:0];
              end
            end
          end
        end
        S_DEAD: begin
          adv_q <= '0;
          y_q   <= FLOOR_Y;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign bus.player_y = y_q;
  assign bus.vel      = vel_q;
  assign bus.adv      = adv_q;
  assign bus.score    = score_q;
  assign bus.dead     = (fsm == S_DEAD);
  assign bus.falling  = ~vel_q[5];
endmodule
